// File: rtl/simple_gen_param_store_if.sv
// Loader byte-stream bus for simple_gen_param_store.
// Latency: n/a (wires only); ld_ready is driven combinationally by the store.
// Backpressure: a byte moves on a rising edge with ld_valid && ld_ready.
//
// Signals:
//   ld_start  - one-cycle pulse, begins or restarts a load at byte 0
//   ld_valid  - loader byte valid
//   ld_data   - loader byte
//   ld_ready  - store accepts ld_data this cycle
// Modports: master (loader side), slave (store side).
interface simple_gen_param_store_if #(
  parameter int WIDTH = 8
);
  logic             ld_start;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;

  modport master (output ld_start, output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_start, input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/simple_gen_param_store.sv
// Run-time loadable weight/bias store serving simple_generator ROM fetches.
// Latency: reads are registered, data 1 cycle after the address; load_done 1 cycle after last byte.
// Backpressure: ld_ready drops while gen_busy or ld_start is high, or outside a load.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   ld               - loader bus (ld_start/ld_valid/ld_data/ld_ready), slave side
//   gen_busy         - generator inference in progress; freezes loading
//   params_valid     - a complete, accepted parameter set is present
//   load_done        - one-cycle pulse when a load finishes
//   load_err         - last load failed its checksum; sticky until next ld_start
//   w1/b1/w2/b2_addr - read addresses; *_data registered read data (0 when out of range)
// Optional feature: define SIMPLE_GEN_PARAM_CHECKSUM_EN to expect a trailing XOR
// checksum byte after the payload.
module simple_gen_param_store #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LATENT_DIM   = 2,
  parameter int HIDDEN_SIZE  = 3,
  parameter int OUTPUT_SIZE  = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  simple_gen_param_store_if.slave        ld,
  input  logic                           gen_busy,
  output logic                           params_valid,
  output logic                           load_done,
  output logic                           load_err,
  input  logic [3:0]                     w1_addr,
  output logic signed [WEIGHT_WIDTH-1:0] w1_data,
  input  logic [1:0]                     b1_addr,
  output logic signed [DATA_WIDTH-1:0]   b1_data,
  input  logic [4:0]                     w2_addr,
  output logic signed [WEIGHT_WIDTH-1:0] w2_data,
  input  logic [3:0]                     b2_addr,
  output logic signed [DATA_WIDTH-1:0]   b2_data
);

  localparam int W1_D = LATENT_DIM * HIDDEN_SIZE;
  localparam int W2_D = HIDDEN_SIZE * OUTPUT_SIZE;

  typedef enum logic [3:0] {
    IDLE, LD_W1, LD_B1_LO, LD_B1_HI, LD_W2, LD_B2_LO, LD_B2_HI, FINISH
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
    , LD_CHK
`endif
  } state_t;

  state_t r_state, w_nxt_state;

  logic signed [WEIGHT_WIDTH-1:0] r_w1 [W1_D];
  logic signed [DATA_WIDTH-1:0]   r_b1 [HIDDEN_SIZE];
  logic signed [WEIGHT_WIDTH-1:0] r_w2 [W2_D];
  logic signed [DATA_WIDTH-1:0]   r_b2 [OUTPUT_SIZE];

  logic [4:0]              r_idx;
  logic [WEIGHT_WIDTH-1:0] r_lo;
  logic                    r_params_valid;
  logic                    w_is_ld;
  logic                    w_xfer;
  logic                    w_last;
  logic                    w_load_err;

  logic signed [WEIGHT_WIDTH-1:0] r_w1_q, r_w2_q;
  logic signed [DATA_WIDTH-1:0]   r_b1_q, r_b2_q;

  always_comb begin
    w_is_ld = 1'b0;
    case (r_state)
      LD_W1, LD_B1_LO, LD_B1_HI, LD_W2, LD_B2_LO, LD_B2_HI: w_is_ld = 1'b1;
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
      LD_CHK: w_is_ld = 1'b1;
`endif
      default: w_is_ld = 1'b0;
    endcase
  end

  assign ld.ld_ready = w_is_ld && !gen_busy && !ld.ld_start;
  assign w_xfer      = ld.ld_valid && ld.ld_ready;

`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
  logic [WEIGHT_WIDTH-1:0] r_csum;
  logic                    r_load_err;
  assign w_load_err = r_load_err;
`else
  assign w_load_err = 1'b0;
`endif

  // w_last flags the final element of the section the FSM is currently filling.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      LD_W1:    w_last = (r_idx == 5'(W1_D - 1));
      LD_B1_HI: w_last = (r_idx == 5'(HIDDEN_SIZE - 1));
      LD_W2:    w_last = (r_idx == 5'(W2_D - 1));
      LD_B2_HI: w_last = (r_idx == 5'(OUTPUT_SIZE - 1));
      default:  w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    if (ld.ld_start) begin
      w_nxt_state = LD_W1;
    end else begin
      case (r_state)
        IDLE:     w_nxt_state = IDLE;
        LD_W1:    if (w_xfer && w_last) w_nxt_state = LD_B1_LO;
        LD_B1_LO: if (w_xfer) w_nxt_state = LD_B1_HI;
        LD_B1_HI: if (w_xfer) w_nxt_state = w_last ? LD_W2 : LD_B1_LO;
        LD_W2:    if (w_xfer && w_last) w_nxt_state = LD_B2_LO;
        LD_B2_LO: if (w_xfer) w_nxt_state = LD_B2_HI;
        LD_B2_HI: if (w_xfer) begin
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
          w_nxt_state = w_last ? LD_CHK : LD_B2_LO;
`else
          w_nxt_state = w_last ? FINISH : LD_B2_LO;
`endif
        end
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
        // A bad checksum still finishes; load_err keeps params_valid low.
        LD_CHK:   if (w_xfer) w_nxt_state = FINISH;
`endif
        FINISH:   w_nxt_state = IDLE;
        default:  w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= '0;
      r_lo           <= '0;
      r_params_valid <= 1'b0;
      for (int i = 0; i < W1_D; i++)        r_w1[i] <= '0;
      for (int i = 0; i < HIDDEN_SIZE; i++) r_b1[i] <= '0;
      for (int i = 0; i < W2_D; i++)        r_w2[i] <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) r_b2[i] <= '0;
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
      r_csum     <= '0;
      r_load_err <= 1'b0;
`endif
    end else if (ld.ld_start) begin
      r_idx          <= '0;
      r_params_valid <= 1'b0;
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
      r_csum     <= '0;
      r_load_err <= 1'b0;
`endif
    end else begin
      if (w_xfer) begin
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
        if (r_state == LD_CHK) r_load_err <= (ld.ld_data != r_csum);
        else                   r_csum     <= r_csum ^ ld.ld_data;
`endif
        case (r_state)
          LD_W1: begin
            r_w1[r_idx[2:0]] <= ld.ld_data;
            r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
          end
          LD_B1_LO: r_lo <= ld.ld_data;
          LD_B1_HI: begin
            r_b1[r_idx[1:0]] <= {ld.ld_data, r_lo};
            r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
          end
          LD_W2: begin
            r_w2[r_idx] <= ld.ld_data;
            r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
          end
          LD_B2_LO: r_lo <= ld.ld_data;
          LD_B2_HI: begin
            r_b2[r_idx[3:0]] <= {ld.ld_data, r_lo};
            r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
          end
          default: ;
        endcase
      end
      if (r_state == FINISH) r_params_valid <= !w_load_err;
    end
  end

  // Registered reads sample the arrays before this edge's writes land,
  // which gives read-before-write on a same-entry collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w1_q <= '0;
      r_b1_q <= '0;
      r_w2_q <= '0;
      r_b2_q <= '0;
    end else begin
      r_w1_q <= (w1_addr < 4'(W1_D))        ? r_w1[w1_addr[2:0]] : '0;
      r_b1_q <= (b1_addr < 2'(HIDDEN_SIZE)) ? r_b1[b1_addr]      : '0;
      r_w2_q <= (w2_addr < 5'(W2_D))        ? r_w2[w2_addr]      : '0;
      r_b2_q <= (b2_addr < 4'(OUTPUT_SIZE)) ? r_b2[b2_addr]      : '0;
    end
  end

  assign w1_data      = r_w1_q;
  assign b1_data      = r_b1_q;
  assign w2_data      = r_w2_q;
  assign b2_data      = r_b2_q;
  assign params_valid = r_params_valid;
  assign load_done    = (r_state == FINISH);
  assign load_err     = w_load_err;

endmodule

// File: tb/tb_simple_gen_param_store.sv
// Directed bench for simple_gen_param_store: reset, full loads, stall, abort,
// collision, out-of-range reads and (when enabled) the checksum path.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_simple_gen_param_store;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gen_busy = 1'b0;
  logic params_valid, load_done, load_err;
  logic [3:0] w1_addr = '0;
  logic [1:0] b1_addr = '0;
  logic [4:0] w2_addr = '0;
  logic [3:0] b2_addr = '0;
  logic signed [7:0]  w1_data, w2_data;
  logic signed [15:0] b1_data, b2_data;

  int n_chk  = 0;
  int n_pass = 0;

  simple_gen_param_store_if #(.WIDTH(8)) ld_if ();

  simple_gen_param_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld           (ld_if.slave),
    .gen_busy     (gen_busy),
    .params_valid (params_valid),
    .load_done    (load_done),
    .load_err     (load_err),
    .w1_addr      (w1_addr),
    .w1_data      (w1_data),
    .b1_addr      (b1_addr),
    .b1_data      (b1_data),
    .w2_addr      (w2_addr),
    .w2_data      (w2_data),
    .b2_addr      (b2_addr),
    .b2_data      (b2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [3:0] a1, input logic [1:0] ab1,
                    input logic [4:0] a2, input logic [3:0] ab2);
    w1_addr = a1; b1_addr = ab1; w2_addr = a2; b2_addr = ab2;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = b;
    #1;
    while (!ld_if.ld_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (!ld_if.ld_ready) chk("ld_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_valid);
    ld_if.ld_start = 1'b1;
    ld_if.ld_valid = with_valid;
    ld_if.ld_data  = 8'h55;
    #1;
    if (with_valid) chk("start_blocks_ready", {31'd0, ld_if.ld_ready}, 32'd0);
    @(negedge clk);
    ld_if.ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
  endtask

  // byte k = (k+1) ^ mask; stall_at/probe_at >= 57 disables those hooks.
  task automatic load(input logic [7:0] mask, input int n, input int stall_at,
                      input int probe_at, input logic [7:0] p_old, input logic [7:0] p_new,
                      input bit bad, input bit start_valid);
    logic [7:0] cs, b;
    int rdy_hi, pulses;
    pulse_start(start_valid);
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = 8'(k + 1) ^ mask;
      cs = cs ^ b;
      if (k == stall_at) begin
        gen_busy = 1'b1; ld_if.ld_valid = 1'b1; ld_if.ld_data = b; rdy_hi = 0;
        for (int i = 0; i < 5; i++) begin
          #1; if (ld_if.ld_ready) rdy_hi++;
          @(negedge clk);
        end
        gen_busy = 1'b0;
        chk("stall_ready_low", rdy_hi, 0);
      end
      if (k == probe_at) w2_addr = 5'd3;
      send_byte(b);
      if (k == probe_at)     chk("collision_old", {24'h0, w2_data}, {24'h0, p_old});
      if (k == probe_at + 1) chk("collision_new", {24'h0, w2_data}, {24'h0, p_new});
    end
    if (n == 57) begin
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
      send_byte(cs ^ {7'd0, bad});
`endif
      #1;
      chk("load_done_timing", {31'd0, load_done}, 32'd1);
      pulses = int'(load_done);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); #1;
        pulses += int'(load_done);
      end
      chk("load_done_once", pulses, 1);
`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
      chk("params_valid_end", {31'd0, params_valid}, {31'd0, !bad});
      chk("load_err_end", {31'd0, load_err}, {31'd0, bad});
`else
      chk("params_valid_end", {31'd0, params_valid}, 32'd1);
      chk("load_err_end", {31'd0, load_err}, 32'd0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_if.ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ld_ready", {31'd0, ld_if.ld_ready}, 32'd0);
    chk("rst_params_valid", {31'd0, params_valid}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    rst_n = 1'b1;
    rd(4'd0, 2'd0, 5'd26, 4'd8);
    chk("rst_w2_26", {24'h0, w2_data}, 32'h0);
    chk("rst_b2_8", {16'h0, b2_data}, 32'h0);
    chk("rst_pv_after", {31'd0, params_valid}, 32'd0);

    // Stray byte in IDLE is dropped
    ld_if.ld_valid = 1'b1; ld_if.ld_data = 8'hEE; #1;
    chk("idle_ready_low", {31'd0, ld_if.ld_ready}, 32'd0);
    @(negedge clk); ld_if.ld_valid = 1'b0;

    // Full unstalled load, byte k = k+1
    load(8'h00, 57, 100, 100, 8'h0, 8'h0, 1'b0, 1'b0);
    rd(4'd5, 2'd0, 5'd0, 4'd8);
    chk("w1_5", {24'h0, w1_data}, 32'h06);
    chk("b1_0", {16'h0, b1_data}, 32'h0807);
    chk("w2_0", {24'h0, w2_data}, 32'h0D);
    chk("b2_8", {16'h0, b2_data}, 32'h3938);

    // Same load with a 5-cycle busy stall at W2[8]
    load(8'h00, 57, 20, 100, 8'h0, 8'h0, 1'b0, 1'b0);
    rd(4'd0, 2'd2, 5'd8, 4'd8);
    chk("stall_w1_0", {24'h0, w1_data}, 32'h01);
    chk("stall_b1_2", {16'h0, b1_data}, 32'h0C0B);
    chk("stall_w2_8", {24'h0, w2_data}, 32'h15);
    chk("stall_b2_8", {16'h0, b2_data}, 32'h3938);
    rd(4'd5, 2'd0, 5'd26, 4'd0);
    chk("stall_w2_26", {24'h0, w2_data}, 32'h27);
    chk("stall_w1_5", {24'h0, w1_data}, 32'h06);

    // Read latency: a new address does not show until the next edge
    rd(4'd0, 2'd0, 5'd0, 4'd0);
    w1_addr = 4'd5; #1;
    chk("lat_hold_old", {24'h0, w1_data}, 32'h01);
    @(negedge clk);
    chk("lat_new", {24'h0, w1_data}, 32'h06);

    // Abort after 20 bytes, then restart with ld_start+ld_valid collision
    load(8'h30, 20, 100, 100, 8'h0, 8'h0, 1'b0, 1'b0);
    chk("abort_pv_clear", {31'd0, params_valid}, 32'd0);
    load(8'hA0, 57, 100, 15, 8'h20, 8'hB0, 1'b0, 1'b1);
    rd(4'd0, 2'd1, 5'd0, 4'd8);
    chk("reload_w1_0", {24'h0, w1_data}, 32'hA1);
    chk("reload_b1_1", {16'h0, b1_data}, 32'hAAA9);
    chk("reload_w2_0", {24'h0, w2_data}, 32'hAD);
    chk("reload_b2_8", {16'h0, b2_data}, 32'h9998);

    // Out-of-range reads
    rd(4'd7, 2'd3, 5'd27, 4'd9);
    chk("oor_w1_7", {24'h0, w1_data}, 32'h0);
    chk("oor_b1_3", {16'h0, b1_data}, 32'h0);
    chk("oor_w2_27", {24'h0, w2_data}, 32'h0);
    chk("oor_b2_9", {16'h0, b2_data}, 32'h0);

`ifdef SIMPLE_GEN_PARAM_CHECKSUM_EN
    // Bad checksum: done pulses, error set, storage keeps the new contents
    load(8'h00, 57, 100, 100, 8'h0, 8'h0, 1'b1, 1'b0);
    rd(4'd5, 2'd0, 5'd0, 4'd8);
    chk("bad_cs_w1_5", {24'h0, w1_data}, 32'h06);
    chk("bad_cs_b2_8", {16'h0, b2_data}, 32'h3938);
    pulse_start(1'b0);
    chk("start_clears_err", {31'd0, load_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
